// File: rtl/seq_16by8_divider_if.sv
// -----------------------------------------------------------------------------
// seq_16by8_divider_if
// Operand/result bundle for the sequential 2N-by-N divider.
//
// Handshake rules, which apply to both channels:
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   The producer holds valid and its data stable until that edge. The consumer
//   may raise or lower ready at any time. Ready never depends combinationally
//   on valid.
//
// Signals (the master is the client, the slave is the divider):
//   in_valid    - operands present               (master -> slave)
//   in_ready    - divider can take an operation  (slave  -> master)
//   dividend    - 2N-bit unsigned numerator      (master -> slave)
//   divisor     - N-bit unsigned denominator     (master -> slave)
//   out_valid   - result available, held         (slave  -> master)
//   out_ready   - client takes the result        (master -> slave)
//   quotient    - 2N-bit floor(dividend/divisor) (slave  -> master)
//   remainder   - N-bit dividend mod divisor     (slave  -> master)
//   div_by_zero - divisor was zero               (slave  -> master)
// -----------------------------------------------------------------------------
interface seq_16by8_divider_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_16by8_divider.sv
// -----------------------------------------------------------------------------
// seq_16by8_divider
// Restoring divider: a 2N-bit unsigned dividend divided by an N-bit unsigned
// divisor. It produces one quotient bit per clock, so a result takes 2N RUN
// cycles. A zero divisor skips RUN and returns quotient all ones, remainder
// dividend[N-1:0] and div_by_zero set.
//
// Ports:
//   clk         - clock; all state changes on the rising edge
//   rst         - asynchronous, active-high reset
//   bus         - slave side of seq_16by8_divider_if (operands and result)
//   o_dbg_state - current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module seq_16by8_divider #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_16by8_divider_if.slave    bus,
  output logic [1:0]            o_dbg_state
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  // r_work starts as the dividend. Each RUN cycle shifts it left: its MSB
  // feeds the partial remainder and the new quotient bit enters at the LSB.
  // After 2N shifts it holds the quotient.
  logic [2*N-1:0] r_work;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_divisor;
  logic [CW-1:0]  r_cnt;

  // Result registers. They change only when a new result is produced, so the
  // outputs stay stable through DONE and keep their values after the handshake.
  logic [2*N-1:0] r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_dbz;

  logic           w_accept;
  logic [N:0]     w_partial;
  logic           w_ge;
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_rem_next;
  logic [2*N-1:0] w_work_next;

  assign w_accept = (r_state == IDLE) && bus.in_valid;

  // The partial remainder is N+1 bits wide, so the shift cannot overflow.
  // The subtraction needs only N bits: it is used only when
  // partial >= divisor, and then the difference is below divisor.
  assign w_partial   = {r_rem, r_work[2*N-1]};
  assign w_ge        = (w_partial >= {1'b0, r_divisor});
  assign w_diff      = w_partial[N-1:0] - r_divisor;
  assign w_rem_next  = w_ge ? w_diff : w_partial[N-1:0];
  assign w_work_next = {r_work[2*N-2:0], w_ge};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_next = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_work    <= bus.dividend;
      r_divisor <= bus.divisor;
      r_rem     <= '0;
      r_cnt     <= CW'(2*N-1);
      if (bus.divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend[N-1:0];
        r_dbz       <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_work <= w_work_next;
      r_rem  <= w_rem_next;
      r_cnt  <= r_cnt - CW'(1);
      // The last RUN step publishes the result in the same edge as the move
      // to DONE.
      if (r_cnt == '0) begin
        r_quotient  <= w_work_next;
        r_remainder <= w_rem_next;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule
